modinv_arbiter: RTL and testbench

- Round-robin arbiter that shares one mod_inv unit between NREQ requesters, e.g. Lagrange coefficient lanes in the TSS datapath.
- Accepts one operand per grant and drives the unit's rising-edge-sensitive start.
- Captures the result, error and done outputs, then returns the result to the granted requester with a tag over a valid/ready response channel.
- Sits between the coefficient lanes and the single shared mod_inv instance.

---
 rtl/modinv_arbiter.sv | 169 ++++++++++++++++
 tb/tb_modinv_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_arbiter.sv
// Round-robin arbiter sharing one mod_inv unit between NREQ requesters.
// Optional watchdog with DRAIN state enabled by defining MODINV_TIMEOUT_EN.
module modinv_arbiter #(
    parameter int NREQ        = 4,
    parameter int W           = 256,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W-1:0]             modulus,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*W-1:0]        req_a,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_inv,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [W-1:0]             inv_a,
    output logic [W-1:0]             inv_p,
    output logic                     inv_start,
    input  logic [W-1:0]             inv_result,
    input  logic                     inv_done,
    input  logic                     inv_error
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
`ifdef MODINV_TIMEOUT_EN
        , DRAIN
`endif
    } state_t;

    state_t          state;
    logic [IDW-1:0]  last;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            grant_any;
    logic [W-1:0]    grant_a;
    int              j;

`ifdef MODINV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
`endif

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last;
        cand      = last;
        j         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(last) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            cand = IDW'(j);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_a = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_a = req_a[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_inv   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            inv_a     <= '0;
            inv_p     <= '0;
            inv_start <= 1'b0;
`ifdef MODINV_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            req_ready <= '0;
            inv_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        req_ready <= NREQ'(1) << grant_idx;
                        last      <= grant_idx;
                        rsp_id    <= grant_idx;
                        inv_a     <= grant_a;
                        inv_p     <= modulus;
                        busy      <= 1'b1;
                        // Zero has no inverse; answer directly without the unit.
                        if (grant_a == '0) begin
                            rsp_err   <= 1'b1;
                            rsp_inv   <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    inv_start <= 1'b1;
                    state     <= WAIT;
`ifdef MODINV_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT: begin
                    if (inv_done) begin
                        rsp_inv   <= inv_result;
                        rsp_err   <= inv_error;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef MODINV_TIMEOUT_EN
                    end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_err   <= 1'b1;
                        rsp_inv   <= '0;
                        wait_cnt  <= '0;
                        state     <= DRAIN;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
`ifdef MODINV_TIMEOUT_EN
                // Let a late unit finish before the next job; its result is dropped.
                DRAIN: begin
                    if (inv_done || wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_arbiter.sv
// Directed bench for modinv_arbiter with a fixed-latency mod_inv unit model.
module tb_modinv_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 256;
    localparam int IDW  = 2;

    localparam logic [W-1:0] PRIME = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [W-1:0] HALF  = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

    logic                clk;
    logic                rst_n;
    logic [W-1:0]        modulus;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_inv;
    logic                rsp_err;
    logic                busy;
    logic [W-1:0]        inv_a;
    logic [W-1:0]        inv_p;
    logic                inv_start;
    logic [W-1:0]        inv_result = '0;
    logic                inv_done   = 1'b0;
    logic                inv_error  = 1'b0;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int start_cnt  = 0;
    int adj_cnt    = 0;
    int grant_cnt  = 0;
    int onehot_err = 0;
    int grant_cyc  = 0;
    int start_cyc  = 0;
    logic prev_start = 1'b0;
    int grant_q[$];

    logic unit_hang = 1'b0;
    logic unit_start_q = 1'b0;
    int   unit_cnt = 0;
    logic [W-1:0] unit_a = '0;

    modinv_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .modulus    (modulus),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_inv    (rsp_inv),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .inv_a      (inv_a),
        .inv_p      (inv_p),
        .inv_start  (inv_start),
        .inv_result (inv_result),
        .inv_done   (inv_done),
        .inv_error  (inv_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit model: rising edge of start launches a 4-cycle job; it ignores rst_n on purpose.
    always @(posedge clk) begin
        unit_start_q <= inv_start;
        inv_done     <= 1'b0;
        if (inv_start && !unit_start_q) begin
            unit_cnt <= 4;
            unit_a   <= inv_a;
        end else if (unit_cnt > 0) begin
            unit_cnt <= unit_cnt - 1;
            if (unit_cnt == 1 && !unit_hang) begin
                inv_done <= 1'b1;
                if (unit_a == 256'd1) begin
                    inv_result <= 256'd1;
                    inv_error  <= 1'b0;
                end else if (unit_a == 256'd2) begin
                    inv_result <= HALF;
                    inv_error  <= 1'b0;
                end else begin
                    inv_result <= '0;
                    inv_error  <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        cyc++;
        if (req_ready != '0) begin
            grant_cnt++;
            grant_cyc = cyc;
            if ($countones(req_ready) != 1) onehot_err++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grant_q.push_back(i);
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (inv_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (prev_start) adj_cnt++;
        end
        prev_start = inv_start;
    endtask

    task automatic applyStimulus(input int idx, input logic [W-1:0] a);
        req_a[idx*W +: W] = a;
        req_valid[idx]    = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, W'(req_ready), '0);
        checkOutput({tag, "_rsp_valid"}, W'(rsp_valid), '0);
        checkOutput({tag, "_rsp_id"},    W'(rsp_id), '0);
        checkOutput({tag, "_rsp_inv"},   rsp_inv, '0);
        checkOutput({tag, "_rsp_err"},   W'(rsp_err), '0);
        checkOutput({tag, "_busy"},      W'(busy), '0);
        checkOutput({tag, "_inv_start"}, W'(inv_start), '0);
        checkOutput({tag, "_inv_a"},     inv_a, '0);
        checkOutput({tag, "_inv_p"},     inv_p, '0);
    endtask

    task automatic collectResponse(input int hold, output logic [IDW-1:0] id,
                                   output logic [W-1:0] inv, output logic err, output int rcyc);
        logic seen;
        logic stable;
        int   g0;
        int   s0;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            stepCycle();
            if (rsp_valid) seen = 1'b1;
        end
        checkOutput("rsp_valid_seen", W'(seen), W'(1));
        id   = rsp_id;
        inv  = rsp_inv;
        err  = rsp_err;
        rcyc = cyc;
        if (seen) begin
            if (hold > 0) begin
                g0     = grant_cnt;
                s0     = start_cnt;
                stable = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    stepCycle();
                    if (!rsp_valid || rsp_id !== id || rsp_inv !== inv || rsp_err !== err) stable = 1'b0;
                end
                checkOutput("hold_stable",   W'(stable), W'(1));
                checkOutput("hold_no_grant", W'(grant_cnt - g0), '0);
                checkOutput("hold_no_start", W'(start_cnt - s0), '0);
            end
            rsp_ready = 1'b1;
            stepCycle();
            rsp_ready = 1'b0;
            checkOutput("rsp_valid_drop", W'(rsp_valid), '0);
        end
    endtask

    logic [IDW-1:0] id;
    logic [W-1:0]   inv;
    logic           err;
    int             rcyc;
    int             s0;
    int             cnt;
    logic           started;

    initial begin
        rst_n     = 1'b1;
        modulus   = PRIME;
        req_valid = '0;
        req_a     = '0;
        rsp_ready = 1'b0;
        #2 rst_n  = 1'b0;
        repeat (3) stepCycle();
        checkResetOutputs("reset");
        rst_n = 1'b1;

        // Single request from requester 1, a=1.
        grant_q.delete();
        s0 = start_cnt;
        applyStimulus(1, 256'd1);
        collectResponse(0, id, inv, err, rcyc);
        checkOutput("t1_id",         W'(id), W'(1));
        checkOutput("t1_inv",        inv, 256'd1);
        checkOutput("t1_err",        W'(err), '0);
        checkOutput("t1_grants",     W'(grant_q.size()), W'(1));
        checkOutput("t1_grant_idx",  W'(grant_q[0]), W'(1));
        checkOutput("t1_starts",     W'(start_cnt - s0), W'(1));
        checkOutput("t1_start_lat",  W'(start_cyc - grant_cyc), W'(1));

        // All four requesters from reset, a=2 each.
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        grant_q.delete();
        s0 = start_cnt;
        for (int r = 0; r < NREQ; r++) applyStimulus(r, 256'd2);
        for (int r = 0; r < NREQ; r++) begin
            collectResponse(0, id, inv, err, rcyc);
            checkOutput($sformatf("t2_id%0d", r),  W'(id), W'(r));
            checkOutput($sformatf("t2_inv%0d", r), inv, HALF);
            checkOutput($sformatf("t2_err%0d", r), W'(err), '0);
        end
        checkOutput("t2_grants", W'(grant_q.size()), W'(4));
        cnt = 0;
        foreach (grant_q[i]) if (grant_q[i] == i) cnt++;
        checkOutput("t2_order",  W'(cnt), W'(4));
        checkOutput("t2_starts", W'(start_cnt - s0), W'(4));

        // Zero operand bypasses the unit.
        s0 = start_cnt;
        applyStimulus(2, '0);
        collectResponse(0, id, inv, err, rcyc);
        checkOutput("t3_id",     W'(id), W'(2));
        checkOutput("t3_inv",    inv, '0);
        checkOutput("t3_err",    W'(err), W'(1));
        checkOutput("t3_starts", W'(start_cnt - s0), '0);

        // Back-pressure: requester 3 wins (pointer at 2), requester 0 waits.
        applyStimulus(3, 256'd1);
        applyStimulus(0, 256'd2);
        collectResponse(10, id, inv, err, rcyc);
        checkOutput("t4_id3",  W'(id), W'(3));
        checkOutput("t4_inv3", inv, 256'd1);
        collectResponse(0, id, inv, err, rcyc);
        checkOutput("t4_id0",  W'(id), W'(0));
        checkOutput("t4_inv0", inv, HALF);

        // Reset while the unit is busy.
        s0 = start_cnt;
        applyStimulus(1, 256'd2);
        started = 1'b0;
        for (int n = 0; n < 50 && !started; n++) begin
            stepCycle();
            if (start_cnt != s0) started = 1'b1;
        end
        checkOutput("t5_started", W'(started), W'(1));
        stepCycle();
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t5_abort");
        stepCycle();
        rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 15; n++) begin
            stepCycle();
            if (rsp_valid || busy) cnt++;
        end
        checkOutput("t5_no_rsp", W'(cnt), '0);
        applyStimulus(2, 256'd1);
        collectResponse(0, id, inv, err, rcyc);
        checkOutput("t5_id",  W'(id), W'(2));
        checkOutput("t5_inv", inv, 256'd1);
        checkOutput("t5_err", W'(err), '0);

`ifdef MODINV_TIMEOUT_EN
        // Hung unit: watchdog plus drain must still produce an error response.
        unit_hang = 1'b1;
        applyStimulus(0, 256'd2);
        collectResponse(0, id, inv, err, rcyc);
        checkOutput("t6_err", W'(err), W'(1));
        checkOutput("t6_inv", inv, '0);
        checkOutput("t6_lat", W'((rcyc - start_cyc) <= 17), W'(1));
        unit_hang = 1'b0;
`endif

        checkOutput("no_adjacent_start", W'(adj_cnt), '0);
        checkOutput("grant_onehot",      W'(onehot_err), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
